// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: pops bytes from the controller FIFO one every three cycles,
// folds E0/F0 prefixes into key events and tracks shift, caps-lock and a new-press counter.
module ps2_scancode_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [7:0]         data,
  input  logic               ready,
  output logic               nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_up,
  output logic               extended,
  output logic [7:0]         ascii,
  output logic               shift,
  output logic               caps,
  output logic [COUNT_W-1:0] press_count
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] byte_q;
  logic       ext_q;
  logic       brk_q;
  logic [8:0] held_code;
  logic       held_vld;

  logic is_ext_pfx;
  logic is_brk_pfx;
  logic is_repeat;
  logic is_shift_key;
  logic is_caps_key;

  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext, input logic upper);
    logic [7:0] letter;
    logic [7:0] res;
    letter = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63; 8'h23: letter = 8'h64;
      8'h24: letter = 8'h65; 8'h2B: letter = 8'h66; 8'h34: letter = 8'h67; 8'h33: letter = 8'h68;
      8'h43: letter = 8'h69; 8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F; 8'h4D: letter = 8'h70;
      8'h15: letter = 8'h71; 8'h2D: letter = 8'h72; 8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74;
      8'h3C: letter = 8'h75; 8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    case (code)
      8'h45: res = 8'h30; 8'h16: res = 8'h31; 8'h1E: res = 8'h32; 8'h26: res = 8'h33;
      8'h25: res = 8'h34; 8'h2E: res = 8'h35; 8'h36: res = 8'h36; 8'h3D: res = 8'h37;
      8'h3E: res = 8'h38; 8'h46: res = 8'h39;
      8'h29: res = 8'h20;
      8'h5A: res = 8'h0D;
      default: res = (letter != 8'h00 && upper) ? (letter - 8'h20) : letter;
    endcase
    if (ext) begin
      res = 8'h00;
    end
    return res;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ready) state_next = POP;
      POP:     state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign is_ext_pfx   = (byte_q == 8'hE0);
  assign is_brk_pfx   = (byte_q == 8'hF0);
  assign is_repeat    = held_vld && (held_code == {ext_q, byte_q});
  assign is_shift_key = !ext_q && (byte_q == 8'h12 || byte_q == 8'h59);
  assign is_caps_key  = !ext_q && (byte_q == 8'h58);

  // Pop strobe is registered from the next state so it is low exactly for the POP cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      byte_q     <= 8'h00;
    end else begin
      state      <= state_next;
      nextdata_n <= (state_next != POP);
      if (state == IDLE && ready) begin
        byte_q <= data;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_up      <= 1'b0;
      extended    <= 1'b0;
      ascii       <= 8'h00;
      shift       <= 1'b0;
      caps        <= 1'b0;
      press_count <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_code   <= 9'h000;
      held_vld    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (state == POP) begin
        if (is_ext_pfx) begin
          ext_q <= 1'b1;
        end else if (is_brk_pfx) begin
          brk_q <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= byte_q;
          key_up    <= brk_q;
          extended  <= ext_q;
          // Uses modifier state from before this event's own update, also for breaks.
          ascii     <= to_ascii(byte_q, ext_q, shift ^ caps);
          ext_q     <= 1'b0;
          brk_q     <= 1'b0;
          if (!brk_q) begin
            held_code <= {ext_q, byte_q};
            held_vld  <= 1'b1;
            if (!is_repeat) press_count <= press_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            if (is_shift_key) shift <= 1'b1;
            if (is_caps_key && !is_repeat) caps <= ~caps;
          end else begin
            if (is_repeat) held_vld <= 1'b0;
            if (is_shift_key) shift <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed bench: a FIFO-modelled PS/2 controller feeds the decoder and a
// per-byte reference model of the key rules predicts every output on every cycle.
module tb_ps2_scancode_decoder;

  logic       clk;
  logic       clr;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_up;
  logic       extended;
  logic [7:0] ascii;
  logic       shift;
  logic       caps;
  logic [7:0] press_count;

  ps2_scancode_decoder #(.COUNT_W(8)) dut (
    .clk(clk), .clr(clr), .data(data), .ready(ready), .nextdata_n(nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_up(key_up), .extended(extended),
    .ascii(ascii), .shift(shift), .caps(caps), .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  logic [7:0] fifo [$];
  int         pushed = 0;
  int         popped = 0;
  int         cyc = 0;
  int         last_pop = 0;
  bit         burst = 0;
  bit         prev_low = 0;

  // Reference model state.
  logic       m_kv, m_up, m_ext, m_shift, m_caps, m_ext_f, m_brk_f, m_held_vld;
  logic [7:0] m_code, m_ascii, m_count;
  logic [8:0] m_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] b, input logic e, input logic upper);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == b) return upper ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == b) return 8'(48 + i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_kv = 0; m_up = 0; m_ext = 0; m_shift = 0; m_caps = 0; m_ext_f = 0; m_brk_f = 0;
    m_held_vld = 0; m_code = 0; m_ascii = 0; m_count = 0; m_held = 0;
    prev_low = 0; burst = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit rep;
    bit is_mod;
    if (b == 8'hE0) m_ext_f = 1;
    else if (b == 8'hF0) m_brk_f = 1;
    else begin
      m_kv = 1; m_code = b; m_up = m_brk_f; m_ext = m_ext_f;
      m_ascii = ref_ascii(b, m_ext_f, m_shift ^ m_caps);
      rep = m_held_vld && (m_held == {m_ext_f, b});
      is_mod = !m_ext_f && (b == 8'h12 || b == 8'h59);
      if (!m_brk_f) begin
        if (!rep) m_count = m_count + 8'd1;
        m_held = {m_ext_f, b}; m_held_vld = 1;
        if (is_mod) m_shift = 1;
        if (!m_ext_f && b == 8'h58 && !rep) m_caps = ~m_caps;
      end else begin
        if (rep) m_held_vld = 0;
        if (is_mod) m_shift = 0;
      end
      m_ext_f = 0; m_brk_f = 0;
    end
  endtask

  task automatic drive_fifo();
    ready = (fifo.size() != 0);
    data  = ready ? fifo[0] : 8'h00;
  endtask

  task automatic tick();
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    check("key_valid", key_valid, m_kv);
    check("key_code", key_code, m_code);
    check("key_up", key_up, m_up);
    check("extended", extended, m_ext);
    check("ascii", ascii, m_ascii);
    check("shift", shift, m_shift);
    check("caps", caps, m_caps);
    check("press_count", press_count, m_count);
    if (clr) check("nextdata_n_rst", nextdata_n, 1'b1);
    m_kv = 0;
    if (!clr && nextdata_n == 1'b0) begin
      check("pop_consecutive", prev_low, 1'b0);
      if (burst) check("pop_interval", cyc - last_pop, 3);
      if (fifo.size() == 0) begin
        check("pop_empty", 1'b1, 1'b0);
      end else begin
        b = fifo.pop_front();
        popped++;
        model_byte(b);
      end
      last_pop = cyc;
      burst = (fifo.size() != 0);
    end else if (fifo.size() == 0) begin
      burst = 0;
    end
    prev_low = !clr && (nextdata_n == 1'b0);
    drive_fifo();
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
    pushed++;
    drive_fifo();
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && fifo.size() != 0; i++) tick();
    check("drain_timeout", fifo.size(), 0);
    repeat (4) tick();
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    model_reset();
    repeat (n) tick();
    clr = 1'b0;
  endtask

  logic [7:0] last_code;

  initial begin
    clr = 1'b1; ready = 1'b0; data = 8'h00;
    model_reset();
    fifo.delete();
    do_reset(3);

    // Single letter make.
    send(8'h1C);
    drain();
    check("r33_ascii", ascii, 8'h61);
    check("r33_count", press_count, 8'd1);
    check("r33_pops", popped, 1);

    do_reset(2);
    foreach (fifo[i]) check("fifo_empty", 1'b1, 1'b0);
    // Shifted letter, then releases.
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    drain();
    check("r34_count", press_count, 8'd2);
    check("r34_shift", shift, 1'b0);

    // Auto-repeat, then a fresh press after release.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    drain();
    check("r35_count", press_count, 8'd4);

    do_reset(2);
    send(8'h58); send(8'hF0); send(8'h58); send(8'h15);
    drain();
    check("r36_caps", caps, 1'b1);
    check("r36_ascii", ascii, 8'h51);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    check("r36_up", key_up, 1'b1);
    check("r36_ext", extended, 1'b1);
    check("r36_ascii_ext", ascii, 8'h00);
    // Repeated prefix keeps break set.
    send(8'hF0); send(8'hF0); send(8'h15);
    drain();
    check("r29_up", key_up, 1'b1);

    // Six bytes in one burst: the pop_interval check covers the 3-cycle cadence.
    for (int i = 0; i < 6; i++) send(letter_codes[i]);
    drain();
    check("r37_pops", popped, pushed);

    // Reset during the POP of a break prefix.
    send(8'hF0);
    begin
      int start;
      start = popped;
      for (int i = 0; i < 50 && popped == start; i++) tick();
      check("r38_popped", popped, start + 1);
    end
    clr = 1'b1;
    #1;
    check("r38_nd_async", nextdata_n, 1'b1);
    check("r38_kv_async", key_valid, 1'b0);
    check("r38_count_async", press_count, 8'd0);
    do_reset(2);
    send(8'h1C);
    drain();
    check("r38_up", key_up, 1'b0);
    check("r38_code", key_code, 8'h1C);

    // Random traffic.
    last_code = 8'h1C;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] code;
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3, 4: code = letter_codes[$urandom_range(0, 25)];
        5: code = digit_codes[$urandom_range(0, 9)];
        6: code = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        7: code = 8'h58;
        8: begin
          code = 8'($urandom_range(0, 255));
          if (code == 8'hE0 || code == 8'hF0) code = 8'h29;
        end
        default: code = last_code;
      endcase
      last_code = code;
      if ($urandom_range(0, 5) == 0) send(8'hE0);
      if ($urandom_range(0, 2) == 0) begin
        send(8'hF0);
        if ($urandom_range(0, 19) == 0) send(8'hF0);
      end
      send(code);
      repeat ($urandom_range(0, 4)) tick();
      if (fifo.size() > 20) drain();
    end
    drain();
    check("final_pops", popped, pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
